// File: rtl/xor_frame_unit.sv
// Streaming bitwise XOR of word pairs through a 2-entry FIFO, with per-frame XOR checksum and
// saturating word count. Define XOR_PARITY_EN to store and present per-word parity.
module xor_frame_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic             out_parity,
    output logic             out_last,
    output logic             sum_valid,
    output logic [WIDTH-1:0] sum_x,
    output logic [CNT_W-1:0] sum_len
);

    typedef enum logic {StIdle, StInFrame} state_e;

    localparam logic [CNT_W-1:0] LenOne = CNT_W'(1);
    localparam logic [CNT_W-1:0] LenMax = {CNT_W{1'b1}};

    logic [WIDTH-1:0] mem_x_q [2];
    logic [1:0]       mem_last_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             ready_en_q;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] in_x;

    state_e           state_q;
    logic [WIDTH-1:0] acc_x_q;
    logic [CNT_W-1:0] acc_len_q;
    logic [CNT_W-1:0] len_inc;
    logic             sum_valid_q;
    logic [WIDTH-1:0] sum_x_q;
    logic [CNT_W-1:0] sum_len_q;

    // ready_en_q keeps in_ready low until the first edge after reset release
    assign in_ready  = ready_en_q && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign in_x      = in_a ^ in_b;
    assign out_x     = mem_x_q[rd_ptr_q];
    assign out_last  = mem_last_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_x_q[0] <= '0;
            mem_x_q[1] <= '0;
            mem_last_q <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (push) begin
                mem_x_q[wr_ptr_q]    <= in_x;
                mem_last_q[wr_ptr_q] <= in_last;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef XOR_PARITY_EN
    logic [1:0] mem_par_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_par_q <= '0;
        end else if (push) begin
            mem_par_q[wr_ptr_q] <= ^in_x;
        end
    end

    assign out_parity = mem_par_q[rd_ptr_q];
`else
    assign out_parity = 1'b0;
`endif

    always_comb begin
        len_inc = acc_len_q;
        if (acc_len_q != LenMax) begin
            len_inc = acc_len_q + LenOne;
        end
    end

    // Frame accumulator advances only on delivered (popped) words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_x_q     <= '0;
            acc_len_q   <= '0;
            sum_valid_q <= 1'b0;
            sum_x_q     <= '0;
            sum_len_q   <= '0;
        end else begin
            sum_valid_q <= 1'b0;
            if (pop) begin
                unique case (state_q)
                    StIdle: begin
                        if (out_last) begin
                            sum_valid_q <= 1'b1;
                            sum_x_q     <= out_x;
                            sum_len_q   <= LenOne;
                        end else begin
                            acc_x_q   <= out_x;
                            acc_len_q <= LenOne;
                            state_q   <= StInFrame;
                        end
                    end
                    StInFrame: begin
                        if (out_last) begin
                            sum_valid_q <= 1'b1;
                            sum_x_q     <= acc_x_q ^ out_x;
                            sum_len_q   <= len_inc;
                            state_q     <= StIdle;
                        end else begin
                            acc_x_q   <= acc_x_q ^ out_x;
                            acc_len_q <= len_inc;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum_x     = sum_x_q;
    assign sum_len   = sum_len_q;

endmodule

// File: tb/tb_xor_frame_unit.sv
// Directed bench for xor_frame_unit: a CNT_W=16 instance plus a CNT_W=2 instance for saturation.
module tb_xor_frame_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_ready;

    logic        in_ready,  out_valid,  out_parity,  out_last,  sum_valid;
    logic [7:0]  out_x,     sum_x;
    logic [15:0] sum_len;
    logic        in_ready2, out_valid2, out_parity2, out_last2, sum_valid2;
    logic [7:0]  out_x2,    sum_x2;
    logic [1:0]  sum_len2;

    int checks = 0;
    int errors = 0;

`ifdef XOR_PARITY_EN
    localparam logic ParExp07 = 1'b1;
`else
    localparam logic ParExp07 = 1'b0;
`endif

    xor_frame_unit #(.WIDTH(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
        .in_b(in_b), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_parity(out_parity), .out_last(out_last), .sum_valid(sum_valid),
        .sum_x(sum_x), .sum_len(sum_len)
    );

    xor_frame_unit #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a),
        .in_b(in_b), .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready),
        .out_x(out_x2), .out_parity(out_parity2), .out_last(out_last2), .sum_valid(sum_valid2),
        .sum_x(sum_x2), .sum_len(sum_len2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic l);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_last  = l;
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        step();
        check("rst_in_ready",   in_ready,   0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_out_x",      out_x,      0);
        check("rst_out_parity", out_parity, 0);
        check("rst_out_last",   out_last,   0);
        check("rst_sum_valid",  sum_valid,  0);
        check("rst_sum_x",      sum_x,      0);
        check("rst_sum_len",    sum_len,    0);
        rst_n = 1'b1;
        step();
        check("in_ready_after_rst", in_ready, 1);

        // Single-word frame
        out_ready = 1'b1;
        drive(1'b1, 8'hF0, 8'h3C, 1'b1);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("s1_out_valid",  out_valid,  1);
        check("s1_out_x",      out_x,      8'hCC);
        check("s1_out_parity", out_parity, 0);
        check("s1_out_last",   out_last,   1);
        check("s1_sum_early",  sum_valid,  0);
        step();
        check("s1_sum_valid",  sum_valid,  1);
        check("s1_sum_x",      sum_x,      8'hCC);
        check("s1_sum_len",    sum_len,    1);
        check("s1_drained",    out_valid,  0);
        step();
        check("s1_sum_pulse",  sum_valid,  0);
        check("s1_sum_hold",   sum_x,      8'hCC);

        // 3-word frame streamed
        drive(1'b1, 8'h01, 8'h00, 1'b0);
        step();
        check("f3_w1", out_x, 8'h01);
        drive(1'b1, 8'h02, 8'h00, 1'b0);
        step();
        check("f3_w2", out_x, 8'h02);
        check("f3_w2_valid", out_valid, 1);
        drive(1'b1, 8'h04, 8'h00, 1'b1);
        step();
        check("f3_w3", out_x, 8'h04);
        check("f3_w3_last", out_last, 1);
        check("f3_no_sum_yet", sum_valid, 0);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check("f3_sum_valid", sum_valid, 1);
        check("f3_sum_x",     sum_x,     8'h07);
        check("f3_sum_len",   sum_len,   3);
        step();
        check("f3_sum_pulse", sum_valid, 0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 8'h11, 8'h00, 1'b0);
        step();
        check("bp_ready_1", in_ready, 1);
        drive(1'b1, 8'h22, 8'h00, 1'b0);
        step();
        check("bp_full_ready", in_ready, 0);
        check("bp_head", out_x, 8'h11);
        drive(1'b1, 8'h44, 8'h00, 1'b1);
        step();
        check("bp_still_full", in_ready, 0);
        check("bp_hold", out_x, 8'h11);
        out_ready = 1'b1;
        step();
        check("bp_pop1_x", out_x, 8'h22);
        check("bp_pop1_ready", in_ready, 1);
        step();
        check("bp_third_x", out_x, 8'h44);
        check("bp_third_last", out_last, 1);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check("bp_sum_valid", sum_valid, 1);
        check("bp_sum_x",     sum_x,     8'h77);
        check("bp_sum_len",   sum_len,   3);
        check("bp_empty",     out_valid, 0);

        // Reset mid-frame
        drive(1'b1, 8'h0F, 8'h00, 1'b0);
        step();
        drive(1'b1, 8'hF0, 8'h00, 1'b0);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        check("mr_in_ready",  in_ready,  0);
        check("mr_out_valid", out_valid, 0);
        check("mr_out_x",     out_x,     0);
        check("mr_sum_valid", sum_valid, 0);
        check("mr_sum_x",     sum_x,     0);
        check("mr_sum_len",   sum_len,   0);
        step();
        rst_n = 1'b1;
        step();
        check("mr_ready_back", in_ready, 1);
        drive(1'b1, 8'hAA, 8'h55, 1'b1);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("mr_out_x_ff", out_x, 8'hFF);
        step();
        check("mr_sum_valid2", sum_valid, 1);
        check("mr_sum_x_ff",   sum_x,     8'hFF);
        check("mr_sum_len1",   sum_len,   1);

        // Counter saturation: 5-word frame
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(1 << i), 8'h00, (i == 4));
            step();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        step();
        check("sat_sum_valid", sum_valid2, 1);
        check("sat_sum_x",     sum_x2,     8'h1F);
        check("sat_sum_len",   sum_len2,   3);
        check("wide_sum_len",  sum_len,    5);

        // Parity of 0x07
        drive(1'b1, 8'h07, 8'h00, 1'b1);
        step();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("par_out_x",  out_x,      8'h07);
        check("par_07",     out_parity, ParExp07);
        step();
        check("par_sum_x",  sum_x,      8'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
